// File: rtl/memory_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : memory_loader_pkg
//  Description : Shared types and constants for the memory loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package memory_loader_pkg;

    // Loader FSM states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Bytes assembled into one memory word (little-endian)
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_BITS      = BYTES_PER_WORD * 8;
    localparam int LANE_WIDTH     = $clog2(BYTES_PER_WORD);

    // Width of the word-count header field
    localparam int LEN_WIDTH      = 16;

endpackage
`default_nettype wire

// File: rtl/memory_loader_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : memory_loader_byte_packer
//  Description : Assembles a little-endian word from accepted stream bytes and
//                flags the byte that completes it.
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_loader_byte_packer
    import memory_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 byte_en,
    input  logic [7:0]           byte_in,
    output logic                 word_valid,
    output logic [WORD_BITS-1:0] word
);

    localparam logic [LANE_WIDTH-1:0] c_last_lane = LANE_WIDTH'(BYTES_PER_WORD - 1);

    logic [LANE_WIDTH-1:0] lane_q, lane_d;
    logic [WORD_BITS-1:0]  shift_q, shift_d;

    // Lane counter and assembly register update
    always_comb begin
        lane_d  = lane_q;
        shift_d = shift_q;
        if (clear) begin
            lane_d  = '0;
            shift_d = '0;
        end else if (byte_en) begin
            shift_d[{lane_q, 3'b000} +: 8] = byte_in;
            lane_d                         = lane_q + 1'b1;
        end
    end

    // Completed word: lower lanes from the register, top lane straight from the stream
    always_comb begin
        word_valid = byte_en && !clear && (lane_q == c_last_lane);
        word       = {byte_in, shift_q[WORD_BITS-9:0]};
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_q  <= '0;
            shift_q <= '0;
        end else begin
            lane_q  <= lane_d;
            shift_q <= shift_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/memory_loader.sv
`default_nettype none
// ============================================================================
//  Module      : memory_loader
//  Description : Boot/debug loader. Receives a framed byte stream (length,
//                data words, XOR checksum) and writes sequential words to
//                data memory from address 0, stalling the pipeline meanwhile.
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_loader
    import memory_loader_pkg::*;
#(
    parameter int ADDR_SIZE = 10,
    parameter int WORD_SIZE = 32
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic                 wr_en,
    output logic [ADDR_SIZE-1:0] wr_addr,
    output logic [WORD_SIZE-1:0] wr_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    // Word counter is one bit wider than the address so a full-depth load
    // can be counted without the address ever wrapping.
    localparam int                  c_cnt_w     = ADDR_SIZE + 1;
    localparam logic [LEN_WIDTH:0]  c_max_words = (LEN_WIDTH + 1)'(2 ** ADDR_SIZE);

    state_t                 state_q, state_d;
    logic                   byte_cnt_q, byte_cnt_d;
    logic [c_cnt_w-1:0]     word_cnt_q, word_cnt_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [7:0]             acc_q, acc_d;
    logic                   err_q, err_d;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_SIZE-1:0]   wr_addr_q, wr_addr_d;
    logic [WORD_SIZE-1:0]   wr_data_q, wr_data_d;

    logic                   w_accept;
    logic                   w_word_valid;
    logic [WORD_BITS-1:0]   w_word;
    logic [LEN_WIDTH-1:0]   w_len_next;
    logic                   w_last_word;

    // Handshake decoded from state only
    always_comb begin
        rx_ready    = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
        w_accept    = rx_ready && rx_valid;
        w_len_next  = {rx_data, len_q[7:0]};
        w_last_word = ({{(LEN_WIDTH - c_cnt_w){1'b0}}, word_cnt_q} == (len_q - LEN_WIDTH'(1)));
    end

    memory_loader_byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (state_q == ST_IDLE),
        .byte_en    (w_accept && (state_q == ST_DATA)),
        .byte_in    (rx_data),
        .word_valid (w_word_valid),
        .word       (w_word)
    );

    // Next-state, counters, checksum and write-port logic
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        len_d      = len_q;
        acc_d      = acc_q;
        err_d      = err_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    byte_cnt_d = 1'b0;
                    word_cnt_d = '0;
                    acc_d      = '0;
                    err_d      = 1'b0;
                    state_d    = ST_LEN;
                end
            end
            ST_LEN: begin
                if (w_accept) begin
                    acc_d = acc_q ^ rx_data;
                    if (!byte_cnt_q) begin
                        len_d[7:0] = rx_data;
                        byte_cnt_d = 1'b1;
                    end else begin
                        len_d      = w_len_next;
                        byte_cnt_d = 1'b0;
                        if ({1'b0, w_len_next} > c_max_words) begin
                            err_d   = 1'b1;
                            state_d = ST_DONE;
                        end else if (w_len_next == '0) begin
                            state_d = ST_CSUM;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (w_accept) begin
                    acc_d = acc_q ^ rx_data;
                end
                if (w_word_valid) begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = word_cnt_q[ADDR_SIZE-1:0];
                    wr_data_d  = w_word;
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (w_last_word) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (w_accept) begin
                    acc_d = acc_q ^ rx_data;
                    if ((acc_q ^ rx_data) != 8'h00) begin
                        err_d = 1'b1;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= 1'b0;
            word_cnt_q <= '0;
            len_q      <= '0;
            acc_q      <= '0;
            err_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            len_q      <= len_d;
            acc_q      <= acc_d;
            err_q      <= err_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Status outputs decoded from registered state
    always_comb begin
        wr_en   = wr_en_q;
        wr_addr = wr_addr_q;
        wr_data = wr_data_q;
        busy    = (state_q != ST_IDLE);
        done    = (state_q == ST_DONE);
        err     = err_q;
    end

endmodule
`default_nettype wire
